// File: rtl/approx_err_monitor_pkg.sv
// Shared types and constants for the approximate-multiplier error monitor.
package approx_mon_pkg;

  localparam int OPND_W    = 4;
  localparam int PROD_W    = 8;
  localparam int ED_W      = 8;
  localparam int DRAIN_CYC = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } mon_state_e;

  // Unsigned absolute difference of two products.
  function automatic logic [ED_W-1:0] abs_diff(input logic [PROD_W-1:0] x,
                                               input logic [PROD_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/approx_err_monitor_if.sv
// Operand/product beat channel between the multiplier side and the monitor.
interface approx_err_monitor_if;
  import approx_mon_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OPND_W-1:0] a;
  logic [OPND_W-1:0] b;
  logic [PROD_W-1:0] approx_p;

  modport master (output in_valid, a, b, approx_p, input in_ready);
  modport slave  (input in_valid, a, b, approx_p, output in_ready);

endinterface

// File: rtl/approx_err_monitor_err_distance_calc.sv
// Second pipeline stage: registers the exact product and the approximate
// product, and presents the error distance derived from those registers.
// Optional macro ERR_BIAS_EN adds the signed difference output.
module err_distance_calc
  import approx_mon_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_vld,
  input  logic [OPND_W-1:0] a,
  input  logic [OPND_W-1:0] b,
  input  logic [PROD_W-1:0] approx_p,
  output logic              out_vld,
  output logic [ED_W-1:0]   ed
`ifdef ERR_BIAS_EN
  ,
  output logic signed [PROD_W:0] diff
`endif
);

  logic              vld_q, vld_d;
  logic [PROD_W-1:0] exact_q, exact_d;
  logic [PROD_W-1:0] prod_q, prod_d;

  // Capture the exact product and the incoming approximation on a valid beat.
  always_comb begin
    vld_d   = in_vld;
    exact_d = exact_q;
    prod_d  = prod_q;
    if (in_vld) begin
      exact_d = {{(PROD_W-OPND_W){1'b0}}, a} * {{(PROD_W-OPND_W){1'b0}}, b};
      prod_d  = approx_p;
    end
  end

  // Stage-2 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q   <= 1'b0;
      exact_q <= '0;
      prod_q  <= '0;
    end else begin
      vld_q   <= vld_d;
      exact_q <= exact_d;
      prod_q  <= prod_d;
    end
  end

  assign out_vld = vld_q;
  assign ed      = abs_diff(prod_q, exact_q);

`ifdef ERR_BIAS_EN
  assign diff = $signed({1'b0, prod_q}) - $signed({1'b0, exact_q});
`endif

endmodule

// File: rtl/approx_err_monitor.sv
// Error-statistics monitor for the 4x4 approximate multiplier.
// Accepts operand/product beats, runs them through a two-stage pipeline and
// accumulates error count, saturating ED sum and maximum ED over SAMPLES beats.
// Optional macro ERR_BIAS_EN adds the signed, saturating err_bias output.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | after reset, waiting for start; no beats accepted
// ST_RUN   | in_ready high, accepting beats until SAMPLES are taken
// ST_DRAIN | pipeline flushing; done follows the last accumulator update
// ST_DONE  | statistics final and held until the next start
module approx_err_monitor
  import approx_mon_pkg::*;
#(
  parameter  int SAMPLES = 256,
  parameter  int ACC_W   = 20,
  localparam int CNT_W   = $clog2(SAMPLES) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  approx_err_monitor_if.slave  mon_if,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     err_cnt,
  output logic [ACC_W-1:0]     err_sum,
  output logic [ED_W-1:0]      max_err
`ifdef ERR_BIAS_EN
  ,
  output logic signed [ACC_W:0] err_bias
`endif
);

  localparam int                 DRAIN_W  = $clog2(DRAIN_CYC + 1);
  localparam logic [CNT_W-1:0]   LAST_SMP = CNT_W'(SAMPLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LD = DRAIN_W'(DRAIN_CYC);

  mon_state_e         state_q, state_d;
  logic [CNT_W-1:0]   smp_q, smp_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               accept;
  logic               clr;

  logic              s1_vld_q, s1_vld_d;
  logic [OPND_W-1:0] s1_a_q, s1_a_d;
  logic [OPND_W-1:0] s1_b_q, s1_b_d;
  logic [PROD_W-1:0] s1_p_q, s1_p_d;

  logic              ed_vld;
  logic [ED_W-1:0]   ed;

  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [ACC_W-1:0]  err_sum_q, err_sum_d;
  logic [ED_W-1:0]   max_err_q, max_err_d;
  logic [ACC_W:0]    sum_ext;

  assign accept = mon_if.in_valid && (state_q == ST_RUN);

  // Sequencing: sample counter counts up to SAMPLES, drain timer counts down.
  // DRAIN holds through DRAIN_CYC+1 edges so done rises one edge after the
  // final accumulator update.
  always_comb begin
    state_d = state_q;
    smp_d   = smp_q;
    drain_d = drain_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
          smp_d   = '0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          smp_d = smp_q + 1'b1;
          if (smp_q == LAST_SMP) begin
            state_d = ST_DRAIN;
            drain_d = DRAIN_LD;
          end
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      smp_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      drain_q <= drain_d;
    end
  end

  // Stage 1 captures the accepted beat.
  always_comb begin
    s1_vld_d = accept;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    s1_p_d   = s1_p_q;
    if (accept) begin
      s1_a_d = mon_if.a;
      s1_b_d = mon_if.b;
      s1_p_d = mon_if.approx_p;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_a_q   <= '0;
      s1_b_q   <= '0;
      s1_p_q   <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s1_a_q   <= s1_a_d;
      s1_b_q   <= s1_b_d;
      s1_p_q   <= s1_p_d;
    end
  end

`ifdef ERR_BIAS_EN
  logic signed [PROD_W:0] ed_diff;
`endif

  err_distance_calc u_edc (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (s1_vld_q),
    .a        (s1_a_q),
    .b        (s1_b_q),
    .approx_p (s1_p_q),
    .out_vld  (ed_vld),
    .ed       (ed)
`ifdef ERR_BIAS_EN
    ,
    .diff     (ed_diff)
`endif
  );

  assign sum_ext = {1'b0, err_sum_q} + (ACC_W+1)'(ed);

  // Accumulate one stage-2 result per cycle; start clears everything.
  always_comb begin
    err_cnt_d = err_cnt_q;
    err_sum_d = err_sum_q;
    max_err_d = max_err_q;
    if (clr) begin
      err_cnt_d = '0;
      err_sum_d = '0;
      max_err_d = '0;
    end else if (ed_vld) begin
      err_cnt_d = err_cnt_q + CNT_W'(ed != '0);
      err_sum_d = sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
      if (ed > max_err_q) max_err_d = ed;
    end
  end

  // Statistic registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      err_sum_q <= '0;
      max_err_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_sum_q <= err_sum_d;
      max_err_q <= max_err_d;
    end
  end

`ifdef ERR_BIAS_EN
  logic signed [ACC_W:0]   err_bias_q, err_bias_d;
  logic        [ACC_W+1:0] bias_ext;

  assign bias_ext = {err_bias_q[ACC_W], err_bias_q}
                  + {{(ACC_W+1-PROD_W){ed_diff[PROD_W]}}, ed_diff};

  // Signed bias accumulation, clamped at both signed limits.
  always_comb begin
    err_bias_d = err_bias_q;
    if (clr) begin
      err_bias_d = '0;
    end else if (ed_vld) begin
      if (bias_ext[ACC_W+1] != bias_ext[ACC_W]) begin
        err_bias_d = bias_ext[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
      end else begin
        err_bias_d = bias_ext[ACC_W:0];
      end
    end
  end

  // Bias register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_bias_q <= '0;
    else        err_bias_q <= err_bias_d;
  end

  assign err_bias = err_bias_q;
`endif

  assign mon_if.in_ready = (state_q == ST_RUN);
  assign busy            = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done            = (state_q == ST_DONE);
  assign err_cnt         = err_cnt_q;
  assign err_sum         = err_sum_q;
  assign max_err         = max_err_q;

endmodule

// File: tb/tb_approx_err_monitor.sv
// Scoreboard bench: dut_a (SAMPLES=4, ACC_W=8) and dut_b (SAMPLES=8, ACC_W=20).
module tb_approx_err_monitor;
  import approx_mon_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a_n, rst_b_n, start_a, start_b;
  approx_err_monitor_if ifa ();
  approx_err_monitor_if ifb ();

  logic       busy_a, done_a;
  logic [2:0] err_cnt_a;
  logic [7:0] err_sum_a;
  logic [7:0] max_err_a;
  logic        busy_b, done_b;
  logic [3:0]  err_cnt_b;
  logic [19:0] err_sum_b;
  logic [7:0]  max_err_b;
`ifdef ERR_BIAS_EN
  logic signed [8:0]  bias_a;
  logic signed [20:0] bias_b;
`endif

  approx_err_monitor #(.SAMPLES(4), .ACC_W(8)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .start(start_a), .mon_if(ifa),
    .busy(busy_a), .done(done_a), .err_cnt(err_cnt_a), .err_sum(err_sum_a),
    .max_err(max_err_a)
`ifdef ERR_BIAS_EN
    , .err_bias(bias_a)
`endif
  );

  approx_err_monitor #(.SAMPLES(8), .ACC_W(20)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .start(start_b), .mon_if(ifb),
    .busy(busy_b), .done(done_b), .err_cnt(err_cnt_b), .err_sum(err_sum_b),
    .max_err(max_err_b)
`ifdef ERR_BIAS_EN
    , .err_bias(bias_b)
`endif
  );

  typedef struct {
    int cnt;
    int sum;
    int mx;
    int bias;
    int acc;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor A: counts accepts, and on the rising edge of done pops and compares.
  int cyc_a = 0, acc_a = 0, last_a = 0;
  logic pd_a = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc_a++;
    if (!rst_a_n) begin
      acc_a = 0;
      pd_a  = 1'b0;
    end else begin
      if (ifa.in_valid && ifa.in_ready) begin
        acc_a++;
        last_a = cyc_a;
      end
      if (done_a && !pd_a) begin
        if (q_a.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_done: got done=1 expected no run pending");
        end else begin
          e = q_a.pop_front();
          chk("a_err_cnt", int'(err_cnt_a), e.cnt);
          chk("a_err_sum", int'(err_sum_a), e.sum);
          chk("a_max_err", int'(max_err_a), e.mx);
          chk("a_accepts", acc_a, e.acc);
          // accept edge lies between negedge k and k+1; done visible at k+4
          chk("a_done_latency", cyc_a - last_a, 4);
          chk("a_busy_in_done", int'(busy_a), 0);
`ifdef ERR_BIAS_EN
          chk("a_err_bias", int'(bias_a), e.bias);
`endif
        end
        acc_a = 0;
      end
      pd_a = done_a;
    end
  end

  // Monitor B: same role for dut_b.
  int cyc_b = 0, acc_b = 0, last_b = 0;
  logic pd_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    cyc_b++;
    if (!rst_b_n) begin
      acc_b = 0;
      pd_b  = 1'b0;
    end else begin
      if (ifb.in_valid && ifb.in_ready) begin
        acc_b++;
        last_b = cyc_b;
      end
      if (done_b && !pd_b) begin
        if (q_b.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_done: got done=1 expected no run pending");
        end else begin
          e = q_b.pop_front();
          chk("b_err_cnt", int'(err_cnt_b), e.cnt);
          chk("b_err_sum", int'(err_sum_b), e.sum);
          chk("b_max_err", int'(max_err_b), e.mx);
          chk("b_accepts", acc_b, e.acc);
          chk("b_done_latency", cyc_b - last_b, 4);
          chk("b_busy_in_done", int'(busy_b), 0);
`ifdef ERR_BIAS_EN
          chk("b_err_bias", int'(bias_b), e.bias);
`endif
        end
        acc_b = 0;
      end
      pd_b = done_b;
    end
  end

  task automatic send_a(input int a, input int b, input int p);
    int   n;
    logic rdy;
    n = 0;
    ifa.in_valid = 1'b1;
    ifa.a = 4'(a); ifa.b = 4'(b); ifa.approx_p = 8'(p);
    do begin
      rdy = ifa.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL a_send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic send_b(input int a, input int b, input int p);
    int   n;
    logic rdy;
    n = 0;
    ifb.in_valid = 1'b1;
    ifb.a = 4'(a); ifb.b = 4'(b); ifb.approx_p = 8'(p);
    do begin
      rdy = ifb.in_ready;
      @(posedge clk); #1;
      n++;
    end while (!rdy && n < 100);
    if (!rdy) begin
      checks++; errors++;
      $display("FAIL b_send_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
  endtask

  task automatic pulse_a();
    start_a = 1'b1; @(posedge clk); #1; start_a = 1'b0;
  endtask

  task automatic pulse_b();
    start_b = 1'b1; @(posedge clk); #1; start_b = 1'b0;
  endtask

  task automatic wait_done_a();
    int n;
    n = 0;
    while (!done_a && n < 50) begin @(posedge clk); #1; n++; end
    if (!done_a) begin
      checks++; errors++;
      $display("FAIL a_done_timeout: got done=0 expected 1 within 50 cycles");
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done_b();
    int n;
    n = 0;
    while (!done_b && n < 50) begin @(posedge clk); #1; n++; end
    if (!done_b) begin
      checks++; errors++;
      $display("FAIL b_done_timeout: got done=0 expected 1 within 50 cycles");
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  // {a, b, approx_p}
  int mix_a[4][3]  = '{'{15,15,225}, '{2,2,4}, '{3,3,5}, '{1,1,1}};
  int rand_b[8][3] = '{'{2,3,6}, '{4,4,20}, '{5,5,25}, '{7,3,21},
                       '{6,6,30}, '{15,1,15}, '{9,9,81}, '{8,8,64}};
  int fresh_b[8][3] = '{'{3,3,5}, '{15,15,225}, '{15,15,0}, '{1,2,2},
                        '{0,7,1}, '{10,10,100}, '{12,12,150}, '{4,5,20}};

  initial begin
    exp_t e;
    rst_a_n = 1'b0; rst_b_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
    ifa.in_valid = 1'b0; ifa.a = '0; ifa.b = '0; ifa.approx_p = '0;
    ifb.in_valid = 1'b0; ifb.a = '0; ifb.b = '0; ifb.approx_p = '0;
    repeat (3) @(posedge clk);
    #1 rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(posedge clk); #1;

    chk("rst_in_ready_a", int'(ifa.in_ready), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_done_a", int'(done_a), 0);
    chk("rst_err_cnt_a", int'(err_cnt_a), 0);
    chk("rst_err_sum_a", int'(err_sum_a), 0);
    chk("rst_max_err_a", int'(max_err_a), 0);
    chk("rst_in_ready_b", int'(ifb.in_ready), 0);
    chk("rst_err_sum_b", int'(err_sum_b), 0);

    // Valid held high in IDLE must not be accepted.
    ifa.in_valid = 1'b1; ifa.a = 4'd3; ifa.b = 4'd3; ifa.approx_p = 8'd5;
    repeat (10) begin @(posedge clk); #1; end
    chk("idle_in_ready", int'(ifa.in_ready), 0);
    chk("idle_accepts", acc_a, 0);
    chk("idle_err_cnt", int'(err_cnt_a), 0);
    chk("idle_busy", int'(busy_a), 0);
    ifa.in_valid = 1'b0;

    // Four identical beats, ED 4 each.
    e = '{cnt:4, sum:16, mx:4, bias:-16, acc:4}; q_a.push_back(e);
    pulse_a();
    for (int i = 0; i < 4; i++) send_a(3, 3, 5);
    ifa.in_valid = 1'b0;
    wait_done_a();
    repeat (5) begin @(posedge clk); #1; end
    chk("hold_err_sum_a", int'(err_sum_a), 16);
    chk("hold_done_a", int'(done_a), 1);

    // Mixed beats, a single error of 4.
    e = '{cnt:1, sum:4, mx:4, bias:-4, acc:4}; q_a.push_back(e);
    pulse_a();
    chk("start_clears_sum_a", int'(err_sum_a), 0);
    for (int i = 0; i < 4; i++) send_a(mix_a[i][0], mix_a[i][1], mix_a[i][2]);
    ifa.in_valid = 1'b0;
    wait_done_a();

    // ED 225 four times saturates the 8-bit sum (and the 9-bit bias at -256).
    e = '{cnt:4, sum:255, mx:225, bias:-256, acc:4}; q_a.push_back(e);
    pulse_a();
    for (int i = 0; i < 4; i++) send_a(15, 15, 0);
    ifa.in_valid = 1'b0;
    wait_done_a();

    // Gappy valid with a start pulse mid-RUN that must be ignored.
    e = '{cnt:2, sum:10, mx:6, bias:-2, acc:8}; q_b.push_back(e);
    pulse_b();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 2)) begin
        ifb.in_valid = 1'b0; @(posedge clk); #1;
      end
      send_b(rand_b[i][0], rand_b[i][1], rand_b[i][2]);
      if (i == 3) begin
        ifb.in_valid = 1'b0;
        pulse_b();
        chk("mid_start_busy_b", int'(busy_b), 1);
      end
    end
    ifb.in_valid = 1'b0;
    wait_done_b();

    // Reset after 3 of 8 accepts discards everything at once.
    pulse_b();
    for (int i = 0; i < 3; i++) send_b(fresh_b[i][0], fresh_b[i][1], fresh_b[i][2]);
    ifb.in_valid = 1'b0;
    rst_b_n = 1'b0;
    #1;
    chk("midrst_in_ready_b", int'(ifb.in_ready), 0);
    chk("midrst_busy_b", int'(busy_b), 0);
    chk("midrst_done_b", int'(done_b), 0);
    chk("midrst_err_cnt_b", int'(err_cnt_b), 0);
    chk("midrst_err_sum_b", int'(err_sum_b), 0);
    chk("midrst_max_err_b", int'(max_err_b), 0);
    repeat (2) @(posedge clk);
    #1 rst_b_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("postrst_idle_b", int'(busy_b), 0);
    chk("postrst_err_sum_b", int'(err_sum_b), 0);

    // Fresh clean run: ED 4, 225, 1, 6 -> cnt 4, sum 236, max 225, bias -222.
    e = '{cnt:4, sum:236, mx:225, bias:-222, acc:8}; q_b.push_back(e);
    pulse_b();
    for (int i = 0; i < 8; i++) send_b(fresh_b[i][0], fresh_b[i][1], fresh_b[i][2]);
    ifb.in_valid = 1'b0;
    wait_done_b();

    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
